pwm_burst_sequencer: RTL and testbench
======================================

# pwm_burst_sequencer

Burst scheduler sitting directly upstream of the dead-time complementary PWM stage (`half_pwm_die`). Accepts a burst request (pulse count, pulse period, dead time, inter-pulse gap) and issues one-cycle `pulse_begin` strobes to the PWM stage. Consumes the stage's `pulse_valid` completion strobe to pace the burst. Holds `die_period` / `pulse_period` stable for the whole burst and reports busy/done/progress to `sys_top`.

## Interface
- `_RAM_WIDTH`, 32, width of period/dead-time/gap fields.
- `CNT_WIDTH`, 16, width of burst length and pulse counter.
- `TIMEOUT_CYCLES`, 1_000_000, watchdog limit in WAIT_DONE (only with `PWM_SEQ_TIMEOUT_EN`).

- `io_clk` in 1: single clock, the PLL output clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: burst request, sampled in IDLE only.
- `abort` in 1: level; forces IDLE.
- `cfg_pulse_period` in `_RAM_WIDTH`: pulse period, latched on accepted start.
- `cfg_die_period` in `_RAM_WIDTH`: dead time, latched on accepted start.
- `cfg_gap` in `_RAM_WIDTH`: idle cycles between a completion and the next strobe.
- `cfg_burst_len` in `CNT_WIDTH`: pulses per burst; 0 means an empty burst.
- `pulse_valid` in 1: one-cycle completion strobe from the PWM stage.
- `pulse_begin` out 1: one-cycle strobe to the PWM stage `io_en`.
- `pulse_period` out `_RAM_WIDTH`: latched period.
- `die_period` out `_RAM_WIDTH`: latched dead time.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle strobe on normal burst completion.
- `pulse_cnt` out `CNT_WIDTH`: completed pulses in the current or last burst.
- `timeout_err` out 1: sticky watchdog flag; tied 0 without the macro.

## Operation
- FSM states: IDLE, ISSUE, WAIT_DONE, GAP, DONE. The state is registered.
- Outputs decoded from the state register:
  - `pulse_begin` = (state==ISSUE).
  - `done` = (state==DONE).
  - `busy` = (state!=IDLE).
- IDLE:
  - `start`=1 and `cfg_burst_len`≠0: latch the three cfg fields and the length, clear `pulse_cnt`, clear `timeout_err`, go to ISSUE.
  - `start`=1 and `cfg_burst_len`=0: clear `pulse_cnt`, go to DONE.
- ISSUE: lasts exactly one cycle, then WAIT_DONE. `pulse_valid` is ignored in this cycle.
- WAIT_DONE, on `pulse_valid`:
  - `pulse_cnt`+1.
  - If the new count equals the latched length, go to DONE.
  - Else if latched gap=0, go to ISSUE.
  - Else load the gap counter with gap−1 and go to GAP.
- GAP: the counter decrements each cycle; at 0 go to ISSUE. GAP lasts exactly `cfg_gap` cycles.
- DONE: one cycle, then IDLE. `pulse_cnt` holds its value until the next accepted start.
- `abort`=1 in any state: next state is IDLE, no `done`, no further `pulse_begin`. Abort beats a simultaneous `pulse_valid`; `pulse_cnt` is not incremented.
- `start` outside IDLE is ignored. cfg changes outside IDLE have no effect.
- `pulse_valid` outside WAIT_DONE is ignored.
- `pulse_cnt` never wraps, because the length is bounded by `CNT_WIDTH`. Comparison uses an unsigned, full-width compare.

## Timing
- Reset: state IDLE; all outputs 0, including `pulse_period`, `die_period` and `pulse_cnt`.
- `start` sampled at edge 0 → `pulse_begin` high in cycle 1, `busy` high from cycle 1.
- `pulse_valid` at cycle k, gap G:
  - Next `pulse_begin` at cycle k+1+G.
  - For the final pulse, `done` at cycle k+1 and `busy` low at k+2.
- A new start is accepted no earlier than the cycle after DONE.
- Reset assertion mid-burst: immediate return to reset values; no `done`.

## Configuration
- Macro `PWM_SEQ_TIMEOUT_EN`.
- Defined:
  - A `$clog2(TIMEOUT_CYCLES+1)`-bit counter runs in WAIT_DONE and clears on entry.
  - Reaching `TIMEOUT_CYCLES` without `pulse_valid` sets `timeout_err` and goes to IDLE with no `done`.
  - `timeout_err` stays set until the next accepted start or reset.
- Undefined: no counter; WAIT_DONE waits indefinitely; `timeout_err` is constant 0.

## Structure
- Package `pwm_seq_pkg` holds:
  - the state encoding (IDLE=0, ISSUE=1, WAIT_DONE=2, GAP=3, DONE=4, 3-bit);
  - the default widths `_RAM_WIDTH` and `CNT_WIDTH`.
- One sub-module, `pwm_gap_timer`:
  - loadable down-counter of `_RAM_WIDTH` bits with `load`, `value` and `zero` outputs;
  - reused for the watchdog when the macro is defined.

## Test plan
- Basic burst:
  - Stimulus: len=3, gap=0, period=10, die=3; bench answers each `pulse_begin` with `pulse_valid` 12 cycles later.
  - Required: 3 `pulse_begin` strobes, each 13 cycles after the previous one; `done` once; `pulse_cnt`=3; `pulse_period`=10 and `die_period`=3 held throughout.
- Gap timing:
  - Stimulus: len=2, gap=5; `pulse_valid` at cycle k.
  - Required: second `pulse_begin` at exactly k+6.
- Empty burst:
  - Stimulus: len=0.
  - Required: `done` in cycle 1, no `pulse_begin`, `pulse_cnt`=0.
- Abort:
  - Stimulus: abort in the same cycle as the 2nd `pulse_valid` of len=4.
  - Required: IDLE next cycle, `pulse_cnt`=1, no `done`, no further strobes; a start with new cfg is then accepted and latched.
- Ignored inputs:
  - Stimulus: `start` and cfg changes during a burst; `pulse_valid` in IDLE and in the ISSUE cycle.
  - Required: no effect on state, counts or latched outputs.
- Watchdog (macro defined):
  - Stimulus: `TIMEOUT_CYCLES`=100; `pulse_valid` withheld.
  - Required: `timeout_err`=1 exactly 100 cycles after entering WAIT_DONE, then IDLE with no `done`; the next start clears the flag.

Source files
------------

// File: rtl/pwm_burst_sequencer_pkg.sv
// pwm_seq_pkg: state encoding and default field widths for the PWM burst sequencer
package pwm_seq_pkg;
    localparam int _RAM_WIDTH = 32;
    localparam int CNT_WIDTH  = 16;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_DONE = 3'd2,
        GAP       = 3'd3,
        DONE      = 3'd4
    } state_t;
endpackage

// File: rtl/pwm_burst_sequencer_if.sv
// pwm_burst_sequencer_if: burst request/config, PWM-stage handshake and status bundle
interface pwm_burst_sequencer_if #(
    parameter int RW = pwm_seq_pkg::_RAM_WIDTH,
    parameter int CW = pwm_seq_pkg::CNT_WIDTH
);
    logic          start, abort, pulse_valid;
    logic          pulse_begin, busy, done, timeout_err;
    logic [RW-1:0] cfg_pulse_period, cfg_die_period, cfg_gap;
    logic [RW-1:0] pulse_period, die_period;
    logic [CW-1:0] cfg_burst_len, pulse_cnt;
    modport master (
        output start, abort, pulse_valid, cfg_pulse_period, cfg_die_period, cfg_gap, cfg_burst_len,
        input  pulse_begin, busy, done, timeout_err, pulse_period, die_period, pulse_cnt
    );
    modport slave (
        input  start, abort, pulse_valid, cfg_pulse_period, cfg_die_period, cfg_gap, cfg_burst_len,
        output pulse_begin, busy, done, timeout_err, pulse_period, die_period, pulse_cnt
    );
endinterface

// File: rtl/pwm_burst_sequencer_gap_timer.sv
// pwm_gap_timer: loadable down-counter that parks at zero; paces gaps and the watchdog
module pwm_gap_timer #(
    parameter int W = 32
) (
    input  logic         io_clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] value,
    output logic         zero
);
    // load wins over counting; the count stops once it reaches zero
    always_ff @(posedge io_clk or negedge rst_n)
        if (!rst_n) value <= '0;
        else if (load) value <= load_value;
        else if (en && !zero) value <= value - 1'b1;
    assign zero = (value == '0);
endmodule

// File: rtl/pwm_burst_sequencer.sv
// pwm_burst_sequencer: issues pulse_begin strobes paced by pulse_valid; PWM_SEQ_TIMEOUT_EN adds a WAIT_DONE watchdog
module pwm_burst_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int _RAM_WIDTH     = pwm_seq_pkg::_RAM_WIDTH,
    parameter int CNT_WIDTH      = pwm_seq_pkg::CNT_WIDTH,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input logic                  io_clk,
    input logic                  rst_n,
    pwm_burst_sequencer_if.slave bus
);
    state_t                  state, state_nx;
    logic [_RAM_WIDTH-1:0]   period_r, die_r, gap_r, gap_value;
    logic [CNT_WIDTH-1:0]    len_r, cnt_r, cnt_inc;
    logic                    accept, take_valid, gap_zero, wd_expire, timeout_r;

    assign accept     = state == IDLE && bus.start && !bus.abort;
    assign take_valid = state == WAIT_DONE && bus.pulse_valid && !bus.abort;
    assign cnt_inc    = cnt_r + 1'b1;

    pwm_gap_timer #(.W(_RAM_WIDTH)) u_gap (
        .io_clk(io_clk), .rst_n(rst_n),
        .load(state == WAIT_DONE && bus.pulse_valid), .en(state == GAP),
        .load_value(gap_r - 1'b1), .value(gap_value), .zero(gap_zero)
    );

`ifdef PWM_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_value;
    logic            wd_zero;
    // reloaded in ISSUE so it restarts on every entry into WAIT_DONE
    pwm_gap_timer #(.W(WD_W)) u_wd (
        .io_clk(io_clk), .rst_n(rst_n),
        .load(state == ISSUE), .en(state == WAIT_DONE),
        .load_value(WD_W'(TIMEOUT_CYCLES - 1)), .value(wd_value), .zero(wd_zero)
    );
    assign wd_expire = state == WAIT_DONE && wd_zero && !bus.pulse_valid;
    // sticky watchdog flag, cleared by the next accepted start
    always_ff @(posedge io_clk or negedge rst_n)
        if (!rst_n) timeout_r <= 1'b0;
        else timeout_r <= accept ? 1'b0 : (wd_expire && !bus.abort) ? 1'b1 : timeout_r;
`else
    assign wd_expire = 1'b0;
    assign timeout_r = 1'b0;
`endif

    // state register
    always_ff @(posedge io_clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    // next-state logic; abort overrides every transition
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (bus.start) state_nx = (bus.cfg_burst_len != '0) ? ISSUE : DONE;
            ISSUE:     state_nx = WAIT_DONE;
            WAIT_DONE: if (bus.pulse_valid) state_nx = (cnt_inc == len_r) ? DONE : (gap_r == '0) ? ISSUE : GAP;
                       else if (wd_expire) state_nx = IDLE;
            GAP:       if (gap_zero) state_nx = ISSUE;
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
        if (bus.abort) state_nx = IDLE;
    end

    // burst registers: cfg latched on a non-empty start, completed-pulse counter
    always_ff @(posedge io_clk or negedge rst_n)
        if (!rst_n) begin
            period_r <= '0;
            die_r    <= '0;
            gap_r    <= '0;
            len_r    <= '0;
            cnt_r    <= '0;
        end else begin
            if (accept && bus.cfg_burst_len != '0) begin
                period_r <= bus.cfg_pulse_period;
                die_r    <= bus.cfg_die_period;
                gap_r    <= bus.cfg_gap;
                len_r    <= bus.cfg_burst_len;
            end
            if (accept) cnt_r <= '0;
            else if (take_valid) cnt_r <= cnt_inc;
        end

    // outputs decoded from the state register and the latched fields
    always_comb begin
        bus.pulse_begin  = state == ISSUE;
        bus.done         = state == DONE;
        bus.busy         = state != IDLE;
        bus.pulse_period = period_r;
        bus.die_period   = die_r;
        bus.pulse_cnt    = cnt_r;
        bus.timeout_err  = timeout_r;
    end
endmodule

// File: tb/tb_pwm_burst_sequencer.sv
// tb_pwm_burst_sequencer: directed and randomized bursts checked against an event-time model
module tb_pwm_burst_sequencer;
    logic        io_clk = 1'b0;
    logic        rst_n  = 1'b0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_period = '0;
    logic [31:0] exp_die    = '0;

    pwm_burst_sequencer_if #(.RW(32), .CW(16)) bus ();
    pwm_burst_sequencer #(._RAM_WIDTH(32), .CNT_WIDTH(16), .TIMEOUT_CYCLES(100)) dut (
        .io_clk(io_clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 io_clk = ~io_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.pulse_valid = 1'b0;
    endtask

    // one burst; expected strobe/done/idle cycles come from the pacing rules:
    // first begin at 1, valid at begin+lat, next begin at valid+1+gap, done at last valid+1
    task automatic run_burst(input int len, input int gap, input int lat, input int abort_at,
                             input bit junk, input logic [31:0] per, input logic [31:0] die,
                             input string tag);
        int exp_b[$];
        int got_b[$];
        int got_done[$];
        int exp_done = -1, exp_idle = -1, exp_cnt = 0, b = 1, v = 0;
        int valid_at = -1, idle_at = -1, bad = 0;
        bit cut = 0;
        if (len == 0) begin
            exp_done = 1;
            exp_idle = 2;
        end else begin
            for (int i = 0; i < len; i++) begin
                if (abort_at >= 0 && b > abort_at) begin cut = 1; break; end
                exp_b.push_back(b);
                v = b + lat;
                if (abort_at >= 0 && v >= abort_at) begin cut = 1; break; end
                exp_cnt++;
                if (i == len - 1) begin exp_done = v + 1; exp_idle = v + 2; end
                b = v + 1 + gap;
            end
            if (cut) exp_idle = abort_at + 1;
            exp_period = per;
            exp_die    = die;
        end
        @(posedge io_clk); #1;
        for (int c = 0; c < 3000; c++) begin
            bus.start       = (c == 0) || (junk && $urandom_range(0, 1) == 1);
            bus.abort       = (c == abort_at);
            bus.pulse_valid = (c == valid_at);
            if (c == 0) begin
                bus.cfg_burst_len    = 16'(len);
                bus.cfg_gap          = 32'(gap);
                bus.cfg_pulse_period = per;
                bus.cfg_die_period   = die;
            end else if (junk) begin
                bus.cfg_burst_len    = 16'($urandom_range(0, 9));
                bus.cfg_gap          = $urandom;
                bus.cfg_pulse_period = $urandom;
                bus.cfg_die_period   = $urandom;
            end
            @(negedge io_clk);
            if (bus.pulse_begin) begin
                got_b.push_back(c);
                valid_at = c + lat;
                if (junk) bus.pulse_valid = 1'b1;
            end
            if (bus.done) got_done.push_back(c);
            if (c > 0 && bus.busy && len != 0 && (bus.pulse_period !== per || bus.die_period !== die)) bad++;
            if (c > 0 && !bus.busy) begin idle_at = c; break; end
            @(posedge io_clk); #1;
        end
        idle_inputs();
        chk($sformatf("%s begin_count", tag), got_b.size(), exp_b.size());
        foreach (exp_b[i]) if (i < got_b.size()) chk($sformatf("%s begin%0d_cycle", tag, i), got_b[i], exp_b[i]);
        chk($sformatf("%s done_count", tag), got_done.size(), (exp_done >= 0) ? 1 : 0);
        if (got_done.size() > 0) chk($sformatf("%s done_cycle", tag), got_done[0], exp_done);
        chk($sformatf("%s idle_cycle", tag), idle_at, exp_idle);
        chk($sformatf("%s pulse_cnt", tag), bus.pulse_cnt, exp_cnt);
        chk($sformatf("%s unstable_latch_cycles", tag), bad, 0);
        chk($sformatf("%s pulse_period", tag), bus.pulse_period, exp_period);
        chk($sformatf("%s die_period", tag), bus.die_period, exp_die);
        chk($sformatf("%s timeout_err", tag), bus.timeout_err, 0);
    endtask

    initial begin
        int g, l, nd;
`ifdef PWM_SEQ_TIMEOUT_EN
        int t_err, t_idle;
`endif
        idle_inputs();
        bus.cfg_burst_len    = '0;
        bus.cfg_gap          = '0;
        bus.cfg_pulse_period = '0;
        bus.cfg_die_period   = '0;
        repeat (3) @(posedge io_clk);
        #1;
        chk("rst busy", bus.busy, 0);
        chk("rst pulse_begin", bus.pulse_begin, 0);
        chk("rst done", bus.done, 0);
        chk("rst pulse_cnt", bus.pulse_cnt, 0);
        chk("rst pulse_period", bus.pulse_period, 0);
        chk("rst die_period", bus.die_period, 0);
        chk("rst timeout_err", bus.timeout_err, 0);
        rst_n = 1'b1;

        @(posedge io_clk); #1;
        bus.pulse_valid = 1'b1;
        repeat (3) @(posedge io_clk);
        #1;
        bus.pulse_valid = 1'b0;
        @(negedge io_clk);
        chk("idle_valid busy", bus.busy, 0);
        chk("idle_valid pulse_cnt", bus.pulse_cnt, 0);

        run_burst(3, 0, 12, -1, 0, 32'd10, 32'd3, "basic");
        run_burst(2, 5, $urandom_range(1, 15), -1, 0, $urandom, $urandom, "gap");
        run_burst(0, 3, 4, -1, 0, $urandom, $urandom, "empty");
        g = $urandom_range(0, 4);
        l = $urandom_range(1, 10);
        run_burst(4, g, l, 2 + 2 * l + g, 0, $urandom, $urandom, "abort");
        run_burst(2, 1, 3, -1, 0, $urandom, $urandom, "post_abort");
        run_burst(3, 2, 4, -1, 1, $urandom, $urandom, "ignored");
        for (int i = 0; i < 6; i++)
            run_burst($urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(1, 15), -1,
                      1'($urandom_range(0, 1)), $urandom, $urandom, $sformatf("rand%0d", i));

        @(posedge io_clk); #1;
        bus.cfg_burst_len    = 16'd3;
        bus.cfg_gap          = 32'd0;
        bus.cfg_pulse_period = 32'd77;
        bus.cfg_die_period   = 32'd5;
        bus.start            = 1'b1;
        @(posedge io_clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge io_clk);
        #1;
        chk("midrst busy_before", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", bus.busy, 0);
        chk("midrst pulse_period", bus.pulse_period, 0);
        chk("midrst die_period", bus.die_period, 0);
        chk("midrst done", bus.done, 0);
        @(posedge io_clk); #1;
        rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge io_clk);
            if (bus.done || bus.busy) nd++;
        end
        chk("midrst quiet_after", nd, 0);

`ifdef PWM_SEQ_TIMEOUT_EN
        t_err  = -1;
        t_idle = -1;
        nd     = 0;
        @(posedge io_clk); #1;
        bus.cfg_burst_len = 16'd1;
        bus.cfg_gap       = 32'd0;
        for (int c = 0; c < 300; c++) begin
            bus.start = (c == 0);
            @(negedge io_clk);
            if (c > 0 && bus.timeout_err && t_err < 0) t_err = c;
            if (bus.done) nd++;
            if (c > 0 && !bus.busy) begin t_idle = c; break; end
            @(posedge io_clk); #1;
        end
        idle_inputs();
        chk("wd timeout_cycle", t_err, 102);
        chk("wd idle_cycle", t_idle, 102);
        chk("wd done_count", nd, 0);
        @(posedge io_clk); #1;
        bus.start = 1'b1;
        @(posedge io_clk); #1;
        bus.start = 1'b0;
        @(negedge io_clk);
        chk("wd cleared_by_start", bus.timeout_err, 0);
        @(posedge io_clk); #1;
        bus.pulse_valid = 1'b1;
        @(posedge io_clk); #1;
        bus.pulse_valid = 1'b0;
        repeat (2) @(posedge io_clk);
        @(negedge io_clk);
        chk("wd followup_busy", bus.busy, 0);
        chk("wd followup_cnt", bus.pulse_cnt, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
